// File: rtl/apb_pkg.sv
// Shared types and constants for the APB controller slice: FSM state
// encoding, the three slave address windows, their one-hot select codes
// and the ACCESS wait-state timeout used when APB_PREADY_EN is defined.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_state_e;

    // Each slave owns a 64 MiB window starting at 0x8000_0000.
    localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
    localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
    localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
    localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;

    localparam logic [2:0] PSEL_NONE = 3'b000;
    localparam logic [2:0] PSEL_SLV0 = 3'b001;
    localparam logic [2:0] PSEL_SLV1 = 3'b010;
    localparam logic [2:0] PSEL_SLV2 = 3'b100;

    // Number of Pready=0 ACCESS cycles tolerated before the transfer aborts.
    localparam int unsigned TIMEOUT_LIMIT = 16;

endpackage

// File: rtl/apb_controller_if.sv
// Bus bundle for apb_controller: request/response handshake on the host
// side and the APB master signals on the slave side. The Pready signal is
// present only when APB_PREADY_EN is defined.
interface apb_controller_if;

    // Host request / response
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // APB master side
    logic        Pwrite;
    logic        Penable;
    logic [2:0]  Pselx;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
`ifdef APB_PREADY_EN
    logic        Pready;
`endif

    // Controller view
    modport master (
`ifdef APB_PREADY_EN
        input  Pready,
`endif
        input  req_valid, req_write, req_addr, req_wdata, Prdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output Pwrite, Penable, Pselx, Paddr, Pwdata
    );

    // Environment view: the host plus the downstream APB slave
    modport slave (
`ifdef APB_PREADY_EN
        output Pready,
`endif
        output req_valid, req_write, req_addr, req_wdata, Prdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  Pwrite, Penable, Pselx, Paddr, Pwdata
    );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: maps a request address onto one of the
// three slave windows and reports whether any window matched.
module apb_addr_decode
    import apb_pkg::*;
(
    input  logic [31:0] addr,
    output logic [2:0]  pselx,
    output logic        hit
);

    // Window compare against the package base/limit constants.
    always_comb begin
        // NOTE: every output gets a default before the ifs so no latch is inferred.
        pselx = PSEL_NONE;
        if (addr >= SLV0_BASE && addr <= SLV0_LIMIT) begin
            pselx = PSEL_SLV0;
        end else if (addr >= SLV1_BASE && addr <= SLV1_LIMIT) begin
            pselx = PSEL_SLV1;
        end else if (addr >= SLV2_BASE && addr <= SLV2_LIMIT) begin
            pselx = PSEL_SLV2;
        end
        hit = (pselx != PSEL_NONE);
    end

endmodule

// File: rtl/apb_controller.sv
// APB master controller: accepts one host request at a time, decodes the
// address, runs a SETUP/ACCESS transfer on a hit and returns a one-cycle
// response pulse. Optional feature macro: APB_PREADY_EN adds the Pready
// input, ACCESS wait states and a 16-cycle timeout that reports rsp_err.
module apb_controller
    import apb_pkg::*;
(
    input  logic             Hclk,
    input  logic             Hresetn,
    apb_controller_if.master bus
);

    apb_state_e  state_q, state_d;
    logic [2:0]  pselx_q, pselx_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        req_ready_q, req_ready_d;

    logic [2:0]  dec_pselx;
    logic        dec_hit;

`ifdef APB_PREADY_EN
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT_LIMIT - 1);
    logic [3:0]  wait_cnt_q, wait_cnt_d;
`endif

    apb_addr_decode u_decode (
        .addr  (bus.req_addr),
        .pselx (dec_pselx),
        .hit   (dec_hit)
    );

    // Next-state and next-output computation for the transfer FSM.
    always_comb begin
        state_d     = state_q;
        pselx_d     = pselx_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_PREADY_EN
        wait_cnt_d  = wait_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    pwrite_d = bus.req_write;
                    paddr_d  = bus.req_addr;
                    pwdata_d = bus.req_wdata;
                    if (dec_hit) begin
                        state_d   = ST_SETUP;
                        pselx_d   = dec_pselx;
                        penable_d = 1'b0;
`ifdef APB_PREADY_EN
                        wait_cnt_d = '0;
`endif
                    end else begin
                        // Decode miss: answer immediately, never touch the bus.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end

            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end

            ST_ACCESS: begin
`ifdef APB_PREADY_EN
                if (bus.Pready) begin
                    state_d     = ST_RESP;
                    pselx_d     = PSEL_NONE;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? 32'h0 : bus.Prdata;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Slave stalled for the full timeout window: abort.
                    state_d     = ST_RESP;
                    pselx_d     = PSEL_NONE;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
`else
                state_d     = ST_RESP;
                pselx_d     = PSEL_NONE;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = pwrite_q ? 32'h0 : bus.Prdata;
`endif
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so req_ready is a clean flop output, high only in IDLE.
        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset drops any transfer in flight.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            // NOTE: every flop here is control or a bus-visible output, so all get a reset value.
            state_q     <= ST_IDLE;
            pselx_q     <= PSEL_NONE;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
`ifdef APB_PREADY_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q     <= state_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            req_ready_q <= req_ready_d;
`ifdef APB_PREADY_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.Pselx     = pselx_q;
    assign bus.Penable   = penable_q;
    assign bus.Pwrite    = pwrite_q;
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;

endmodule

// File: doc/apb_controller.md
APB_CONTROLLER -- requirements
Module: apb_controller

Interface
REQ-001 The block SHALL have one clock, Hclk, and all state SHALL change on its rising edge.
REQ-002 Hresetn, input, 1 bit: asynchronous active-low reset.
REQ-003 req_valid, input, 1 bit: request present.
REQ-004 req_write, input, 1 bit: 1 = write, 0 = read.
REQ-005 req_addr, input, 32 bits: request address.
REQ-006 req_wdata, input, 32 bits: write data.
REQ-007 req_ready, output, 1 bit: request accepted this cycle when req_valid is also high.
REQ-008 rsp_valid, output, 1 bit: response pulse, one cycle wide.
REQ-009 rsp_rdata, output, 32 bits: read data.
REQ-010 rsp_err, output, 1 bit: decode miss or timeout.
REQ-011 Pwrite, output, 1 bit; Penable, output, 1 bit; Pselx, output, 3 bits, one-hot; Paddr, output, 32 bits; Pwdata, output, 32 bits. These are the APB master outputs to the downstream slave.
REQ-012 Prdata, input, 32 bits: slave read data.
REQ-013 Pready, input, 1 bit: slave ready. This port SHALL exist only with APB_PREADY_EN defined.

Function
REQ-014 The FSM SHALL have the states ST_IDLE, ST_SETUP, ST_ACCESS and ST_RESP.
REQ-015 ST_IDLE behaviour:
- req_ready=1.
- On req_valid, the block SHALL latch req_write, req_addr and req_wdata into Pwrite, Paddr and Pwdata.
- On a decode hit, the next state SHALL be ST_SETUP.
- On a decode miss, the next state SHALL be ST_RESP with the error flag set.
REQ-016 Address decode:
- 0x8000_0000–0x83FF_FFFF -> Pselx=3'b001.
- 0x8400_0000–0x87FF_FFFF -> Pselx=3'b010.
- 0x8800_0000–0x8BFF_FFFF -> Pselx=3'b100.
- Any other address is a miss; Pselx SHALL stay 3'b000 and no APB transfer SHALL occur.
REQ-017 ST_SETUP SHALL last exactly one cycle: Pselx=decoded value, Penable=0, then go to ST_ACCESS.
REQ-018 ST_ACCESS behaviour:
- Pselx held, Penable=1.
- On completion, the block SHALL capture Prdata into rsp_rdata for reads (writes: rsp_rdata=0) and go to ST_RESP.
REQ-019 ST_RESP SHALL last one cycle:
- rsp_valid=1, rsp_err per the error flag.
- Pselx=0, Penable=0.
- Next state ST_IDLE.
REQ-020 req_ready SHALL be 0 in every state except ST_IDLE; a request held during busy states SHALL be accepted on the first ST_IDLE cycle.
REQ-021 Hit latency with no wait states: accept edge at cycle 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3. Maximum throughput SHALL be one transfer per 4 cycles.
REQ-022 Miss latency: rsp_valid SHALL assert in the cycle after accept, with rsp_err=1 and rsp_rdata=0.
REQ-023 Paddr, Pwdata and Pwrite SHALL be registered and SHALL hold their last values outside transfers; Pselx and Penable SHALL be 0 outside SETUP/ACCESS.
REQ-024 Penable SHALL never be 1 while Pselx=0.

Reset
REQ-025 Hresetn low SHALL immediately force:
- state=ST_IDLE.
- Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0.
- rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Wait counter=0.
- req_ready=1.
REQ-026 A reset mid-transfer SHALL drop the transfer; no rsp_valid SHALL be issued for it.

Configuration
REQ-027 With APB_PREADY_EN defined:
- ST_ACCESS SHALL complete only when Pready=1.
- A 4-bit wait counter SHALL increment per ACCESS cycle with Pready=0.
- After 16 wait cycles the block SHALL abort to ST_RESP with rsp_err=1 and rsp_rdata=0.
- The counter SHALL clear on entry to ST_SETUP.
REQ-028 Without APB_PREADY_EN:
- The Pready port SHALL be absent.
- ST_ACCESS SHALL complete after exactly one cycle.
- There SHALL be no wait counter and no timeout error.

Structure
REQ-029 Shared package apb_pkg SHALL hold:
- the state typedef;
- the address-range base/limit constants;
- the Pselx one-hot codes;
- the timeout limit constant (16).
REQ-030 The address decoder SHALL be the combinational sub-module apb_addr_decode (addr in; Pselx and hit out). All sequential logic SHALL be in apb_controller.

Verification
REQ-031 Write to 0x8400_0010, data 0xDEAD_BEEF: expect Pselx=010 with Penable=0 in cycle 1, Penable=1 in cycle 2, then rsp_valid=1, rsp_err=0, rsp_rdata=0 in cycle 3.
REQ-032 Read from 0x8000_0004 with Prdata=0x1234_5678: expect rsp_rdata=0x1234_5678 and rsp_valid in cycle 3.
REQ-033 Read from 0x9000_0000: expect Pselx never nonzero, and rsp_valid=1, rsp_err=1 in cycle 1.
REQ-034 Back-to-back requests with req_valid held high: expect req_ready low for 3 cycles after each accept and the second accept exactly 4 cycles after the first.
REQ-035 With APB_PREADY_EN: Pready low for 3 cycles -> ACCESS lasts 4 cycles and the response is correct; Pready stuck low -> rsp_err=1 after 16 wait cycles.
REQ-036 Hresetn driven low during ST_ACCESS: expect Pselx=0 and Penable=0 asynchronously, and no rsp_valid after reset release.
